alu_seq: RTL and testbench

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It accepts one operation per transaction over a valid/ready input port and returns a registered result with Zero/Carry/Overflow/Negative flags over a valid/ready output port. It adds logical shifts and an iterative unsigned multiply to ADD/SUB/AND/OR/XOR. It sits between an issuing controller and a result consumer that may apply backpressure.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 32 +++
 rtl/alu_mul_iter.sv | 81 ++++++++
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the handshaked ALU (alu_seq) and its helpers.
//   op_e    : 3-bit opcode (ADD, SUB, AND, OR, XOR, SHL, SHR, MUL)
//   state_e : control FSM states (IDLE, MUL_RUN, DONE)
//   flags_t : registered flag bundle {carry, zero, overflow, negative}
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MUL_RUN = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for alu_seq.
//   Issue side   : in_valid, in_ready, A, B, Sel
//   Result side  : out_valid, out_ready, Result, Carry, Zero, Overflow, Negative
//   master modport = issuer + consumer, slave modport = the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             Zero;
  logic             Overflow;
  logic             Negative;

  modport master (
    output in_valid, A, B, Sel, out_ready,
    input  in_ready, out_valid, Result, Carry, Zero, Overflow, Negative
  );

  modport slave (
    input  in_valid, A, B, Sel, out_ready,
    output in_ready, out_valid, Result, Carry, Zero, Overflow, Negative
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one partial product
// per clock, WIDTH steps per multiply.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : load operands a_i/b_i and begin a new multiply
//   a_i, b_i    : WIDTH-bit unsigned operands
//   done_o      : high during the cycle of the final step
//   product_o   : 2*WIDTH-bit product; valid while done_o is high
// The final step is not written back into the accumulator: product_o is the
// accumulator plus the current step's addend, so the consumer can register
// the full product on the same edge that would have completed the last step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend_s;
  logic [2*WIDTH-1:0] step_s;

  // Partial product for the current multiplier bit and the resulting sum.
  always_comb begin
    if (mplier_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {(2*WIDTH){1'b0}};
    end
    step_s = acc_q + addend_s;
  end

  assign product_o = step_s;
  assign done_o    = (cnt_q == CW'(1'b1));

  // Next-state: load on start, otherwise shift-add while steps remain.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != {CW{1'b0}}) begin
      acc_d    = step_s;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1'b1);
    end else begin
      cnt_d    = {CW{1'b0}};
    end
  end

  // Multiplier state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if.slave
//     in_valid/in_ready  : accept one op (A, B, Sel) per handshake
//     out_valid/out_ready: hand the registered Result and flags
//                          {Carry, Zero, Overflow, Negative} to the consumer
// Ops: ADD, SUB, AND, OR, XOR, SHL, SHR (shift amount = low bits of B) and
// unsigned MUL (low WIDTH bits). Single-cycle ops register their result on
// the accepting edge; MUL runs an iterative multiplier for WIDTH cycles.
// in_ready depends combinationally on out_ready so a result can be consumed
// and a new op accepted on the same edge.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  flags_t             flags_q;

  logic               in_ready_s;
  logic               accept_s;
  logic               mul_op_s;
  logic               start_mul_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  op_e                op_s;
  logic [SHW-1:0]     shamt_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     shr_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic               ovf_s;
  flags_t             flags_s;

  // Zero and Negative are derived from the result for every op.
  function automatic flags_t mk_flags(input logic [WIDTH-1:0] r,
                                      input logic c,
                                      input logic v);
    flags_t f;
    f.carry    = c;
    f.zero     = (r == {WIDTH{1'b0}});
    f.overflow = v;
    f.negative = r[WIDTH-1];
    return f;
  endfunction

  assign in_ready_s  = !rst && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && bus.out_ready));
  assign accept_s    = bus.in_valid && in_ready_s;
  assign op_s        = op_e'(bus.Sel);
  assign mul_op_s    = (op_s == OP_MUL) && (MUL_EN != 32'sd0);
  assign start_mul_s = accept_s && mul_op_s;

  // Single-cycle datapath: result, carry and overflow for the op on the bus.
  always_comb begin
    shamt_s = bus.B[SHW-1:0];
    sum_s   = {1'b0, bus.A} + {1'b0, bus.B};
    // Top bit of the extended difference is the borrow (A < B unsigned).
    diff_s  = {1'b0, bus.A} - {1'b0, bus.B};
    // Extra bit above/below the operand catches the last bit shifted out;
    // it stays 0 for a zero shift amount.
    shl_s   = {1'b0, bus.A} << shamt_s;
    shr_s   = {bus.A, 1'b0} >> shamt_s;
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_s)
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = diff_s[WIDTH-1:0];
        carry_s = diff_s[WIDTH];
        ovf_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                  (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND: res_s = bus.A & bus.B;
      OP_OR:  res_s = bus.A | bus.B;
      OP_XOR: res_s = bus.A ^ bus.B;
      OP_SHL: begin
        res_s   = shl_s[WIDTH-1:0];
        carry_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_s   = shr_s[WIDTH:1];
        carry_s = shr_s[0];
      end
      // Without a multiplier MUL completes at once with a zero result;
      // with one, this value is never registered.
      OP_MUL: res_s = {WIDTH{1'b0}};
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
    flags_s = mk_flags(res_s, carry_s, ovf_s);
  end

  generate
    if (MUL_EN != 32'sd0) begin : g_mul
      alu_mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_mul_s),
        .a_i       (bus.A),
        .b_i       (bus.B),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
      );
    end else begin : g_no_mul
      assign mul_done_s = 1'b0;
      assign mul_prod_s = {(2*WIDTH){1'b0}};
    end
  endgenerate

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= '{carry: 1'b0, zero: 1'b0, overflow: 1'b0, negative: 1'b0};
    end else begin
      case (state_q)
        // IDLE and a consumed DONE behave the same when a new op arrives;
        // accept_s in DONE already implies out_ready.
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            if (mul_op_s) begin
              state_q     <= ST_MUL_RUN;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_s;
              flags_q     <= flags_s;
            end
          end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end else begin
            state_q     <= state_q;
            out_valid_q <= out_valid_q;
          end
        end
        ST_MUL_RUN: begin
          if (mul_done_s) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod_s[WIDTH-1:0];
            // Carry reports a product that does not fit in WIDTH bits.
            flags_q     <= mk_flags(mul_prod_s[WIDTH-1:0],
                                    |mul_prod_s[2*WIDTH-1:WIDTH], 1'b0);
          end else begin
            state_q     <= ST_MUL_RUN;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = result_q;
  assign bus.Carry     = flags_q.carry;
  assign bus.Zero      = flags_q.zero;
  assign bus.Overflow  = flags_q.overflow;
  assign bus.Negative  = flags_q.negative;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8, MUL_EN=1).
// The issuer pushes the expected response when an op is accepted; a separate
// monitor pops and compares whenever a result is handed over.
module tb_alu_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
    logic         n;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH (W),
    .MUL_EN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t   e;
    int     m;
    int     sa;
    int     sb;
    int     s;
    int     r;
    int     n;
    longint p;
    bit     c;
    bit     v;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    n  = b % W;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      0: begin r = (a + b) % m; c = (a + b) >= m; s = sa + sb; v = (s > m / 2 - 1) || (s < -m / 2); end
      1: begin r = (a - b + m) % m; c = a < b; s = sa - sb; v = (s > m / 2 - 1) || (s < -m / 2); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a << n) % m; c = (n != 0) && (((a >> (W - n)) & 1) == 1); end
      6: begin r = a >> n; c = (n != 0) && (((a >> (n - 1)) & 1) == 1); end
      default: begin p = longint'(a) * longint'(b); r = int'(p % longint'(m)); c = p >= longint'(m); end
    endcase
    e.r = r[W-1:0];
    e.c = c;
    e.v = v;
    e.z = (r == 0);
    e.n = (r >= m / 2);
    return e;
  endfunction

  function automatic exp_t mk(input int r, input bit c, input bit v, input bit z, input bit n);
    exp_t e;
    e.r = r[W-1:0];
    e.c = c;
    e.v = v;
    e.z = z;
    e.n = n;
    return e;
  endfunction

  // Called just after a rising edge; leaves in_valid high on return.
  task automatic send(input int op, input int a, input int b, input exp_t e,
                      input bit rand_rdy, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.Sel      = op[2:0];
    bus.A        = a[W-1:0];
    bus.B        = b[W-1:0];
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        acc = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic run_directed(input string name, input int op, input int a, input int b,
                              input exp_t e, input int lat);
    int waits;
    int l;
    bit seen;
    bit busy_ok;
    send(op, a, b, e, 1'b0, waits);
    bus.in_valid = 1'b0;
    l       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      l++;
      if (bus.out_valid) seen = 1'b1;
      else if (bus.in_ready) busy_ok = 1'b0;
    end
    check({name, " latency"}, 32'(l), 32'(lat));
    if (op == 7) check({name, " in_ready while running"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every handed-over result with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected output: Result 0x%0h with no pending op", bus.Result);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(bus.Result), 32'(e.r));
          check("flags CZVN", 32'({bus.Carry, bus.Zero, bus.Overflow, bus.Negative}),
                32'({e.c, e.z, e.v, e.n}));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waits;
    int   ov_cnt;
    int   op;
    int   a;
    int   b;
    exp_t e;

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.Sel       = 3'b000;
    bus.A         = 8'h01;
    bus.B         = 8'h01;
    bus.out_ready = 1'b1;

    // Reset state, with an op held on the inputs that must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset result", 32'(bus.Result), 32'd0);
    check("reset flags", 32'({bus.Carry, bus.Zero, bus.Overflow, bus.Negative}), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors: op, A, B, {R, C, V, Z, N}, latency.
    run_directed("add 7f+01", 0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b1, 1'b0, 1'b1), 1);
    run_directed("sub 00-01", 1, 8'h00, 8'h01, mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1), 1);
    run_directed("sub 80-01", 1, 8'h80, 8'h01, mk(8'h7F, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    run_directed("sub 55-55", 1, 8'h55, 8'h55, mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    run_directed("shl 81<<1", 5, 8'h81, 8'h01, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0), 1);
    run_directed("shr 01>>0", 6, 8'h01, 8'h00, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    run_directed("shr 80>>7", 6, 8'h80, 8'h07, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0), 1);
    run_directed("mul ff*ff", 7, 8'hFF, 8'hFF, mk(8'h01, 1'b1, 1'b0, 1'b0, 1'b0), 9);
    run_directed("mul 0f*03", 7, 8'h0F, 8'h03, mk(8'h2D, 1'b0, 1'b0, 1'b0, 1'b0), 9);

    // Backpressure: result held for 3 cycles while the next op waits.
    bus.out_ready = 1'b0;
    send(0, 8'h10, 8'h20, mk(8'h30, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, waits);
    bus.Sel = 3'b100;
    bus.A   = 8'hAA;
    bus.B   = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
      check("stall result", 32'(bus.Result), 32'h30);
      check("stall flags", 32'({bus.Carry, bus.Zero, bus.Overflow, bus.Negative}), 32'd0);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(4, 8'hAA, 8'h55, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0, waits);
    check("same-cycle accept waits", 32'(waits), 32'd0);
    send(1, 8'h10, 8'h20, mk(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0, waits);
    check("back-to-back accept waits", 32'(waits), 32'd0);
    drain();

    // Reset four cycles into a MUL: the op is abandoned with no output.
    send(7, 8'h33, 8'h44, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, waits);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready during rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("mid-mul reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid-mul reset result", 32'(bus.Result), 32'd0);
    check("mid-mul reset flags", 32'({bus.Carry, bus.Zero, bus.Overflow, bus.Negative}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after rst", 32'(bus.in_ready), 32'd1);
    ov_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("no pulse from abandoned mul", 32'(ov_cnt), 32'd0);
    @(posedge clk);
    #1;
    run_directed("add 02+03", 0, 8'h02, 8'h03, mk(8'h05, 1'b0, 1'b0, 1'b0, 1'b0), 1);

    // Randomised ops with random consumer backpressure and issue gaps.
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      if ((i % 4) == 0) b = b % W;
      e = model(op, a, b);
      send(op, a, b, e, 1'b1, waits);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
